mindy_job_launcher: RTL and testbench
=====================================

Name: mindy_job_launcher

Overview:
- Initiator side of the core-reset handshake.
- Accepts job requests over a valid/ready interface and pulses new_job to the core-reset block. It then waits for the core reset (core_resetn) to assert and release, and waits a settle interval.
- After the settle interval it launches the core with a start pulse, waits for done, and returns one status response per job.
- Sits between the host command path and the core-reset/core logic.

Parameters:
- ID_W, 8, width of job identifier.
- SETTLE_CYCLES, 4, cycles to wait after core_resetn rises before core_start (1..255).
- ASSERT_TIMEOUT, 8, max cycles after new_job for core_resetn to go low (1..255).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- job_valid  in  1  job request valid.
- job_ready  out  1  launcher can accept a job.
- job_id  in  ID_W  identifier of requested job.
- new_job  out  1  one-cycle pulse requesting core reset.
- core_resetn  in  1  active-low core reset from reset block.
- core_start  out  1  one-cycle pulse launching core.
- core_job_id  out  ID_W  latched job id, stable from accept until response taken.
- core_done  in  1  core completion pulse/level.
- core_error  in  1  sampled with core_done; 1 = job failed.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  id of completed job.
- rsp_status  out  2  00 ok, 01 core error, 10 reset timeout, 11 watchdog timeout.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (sync, active-high): state=IDLE; job_ready=1, new_job=0, core_start=0, rsp_valid=0, busy=0. core_job_id, rsp_id and rsp_status are cleared to 0. All counters are cleared.
- job_ready=1 only in IDLE. Accept occurs when job_valid&job_ready at a rising edge: latch job_id into core_job_id and go to PULSE.
- PULSE: new_job=1 for exactly this one cycle, then go to WAIT_ASSERT with the timeout counter cleared.
- WAIT_ASSERT:
  - If core_resetn=0, go to WAIT_RELEASE.
  - Otherwise increment the counter. When the counter reaches ASSERT_TIMEOUT, go to REPORT with status 10.
- WAIT_RELEASE: wait until core_resetn=1, with no timeout. Then go to SETTLE with the counter cleared.
- SETTLE: count SETTLE_CYCLES cycles with core_resetn=1, then go to START.
  - If core_resetn drops during SETTLE, return to WAIT_RELEASE. The counter is cleared on re-entry.
- START: core_start=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: on core_done=1, capture core_error and go to REPORT with status {0,core_error}.
  - core_done is ignored in every other state.
- REPORT: rsp_valid=1, rsp_id=core_job_id, rsp_status held stable until rsp_valid&rsp_ready. Then go to IDLE.
  - rsp_valid never drops without a handshake.
  - rsp_ready with no pending response has no effect.
- Latency, accept to new_job: 1 cycle (new_job is high the cycle after the accept edge).
- Latency, core_resetn release to core_start: SETTLE_CYCLES+1 cycles.
- Latency, core_done to rsp_valid: 1 cycle.
- Response to accept: same-cycle job re-accept is impossible (job_ready=0 in REPORT). Minimum job-to-job spacing is 1 IDLE cycle.
- core_resetn low while in WAIT_DONE (external reset mid-job): go to REPORT with status 01.
- Reset mid-operation: abandon the job immediately and produce no response. Outputs return to reset values the next cycle.
- Counters are 8 bits, saturating; never wrap.

Optional Feature:
- Macro MINDY_JOB_WATCHDOG_EN.
- Defined:
  - Adds input watchdog_limit (32 bits) and a 32-bit cycle counter. The counter clears on START and increments each WAIT_DONE cycle.
  - When the counter equals watchdog_limit with no core_done, go to REPORT with status 11.
  - watchdog_limit=0 disables the watchdog.
  - If core_done and expiry occur in the same cycle, core_done wins.
- Undefined: no watchdog_limit port and no counter. WAIT_DONE waits indefinitely. Status 11 is never produced.

Test Plan:
- Normal job, job_id=0x5A: core_resetn low 20 cycles starting 1 cycle after new_job; core_done with core_error=0 10 cycles after core_start -> one new_job pulse; core_start exactly 5 cycles after core_resetn rises; rsp_id=0x5A, status=00.
- core_resetn never drops after new_job -> rsp_valid with status=10 after ASSERT_TIMEOUT (8) WAIT_ASSERT cycles; core_start never pulses.
- core_resetn glitches low at settle cycle 2 -> settle restarts; core_start 5 cycles after final rise; status=00.
- core_done with core_error=1, rsp_ready held low 6 cycles -> rsp_valid/rsp_id/rsp_status=01 stable all 6 cycles; job_ready=0 until handshake, 1 the cycle after.
- reset asserted in WAIT_DONE -> next cycle: rsp_valid=0, job_ready=1, busy=0; a later core_done produces no response.
- MINDY_JOB_WATCHDOG_EN, watchdog_limit=100, no core_done -> status=11 exactly 100 WAIT_DONE cycles after core_start; with watchdog_limit=0, no response after 1000 cycles.

Source files
------------

// File: rtl/mindy_job_launcher.sv
// Job launcher: accepts a job, sequences core reset, settle and start, reports status.
// Optional watchdog on WAIT_DONE enabled with `define MINDY_JOB_WATCHDOG_EN.
module mindy_job_launcher #(
    parameter int ID_W           = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int ASSERT_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            job_valid,
    output logic            job_ready,
    input  logic [ID_W-1:0] job_id,
    output logic            new_job,
    input  logic            core_resetn,
    output logic            core_start,
    output logic [ID_W-1:0] core_job_id,
    input  logic            core_done,
    input  logic            core_error,
`ifdef MINDY_JOB_WATCHDOG_EN
    input  logic [31:0]     watchdog_limit,
`endif
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [ID_W-1:0] rsp_id,
    output logic [1:0]      rsp_status,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT_ASSERT,
        WAIT_RELEASE,
        SETTLE,
        START,
        WAIT_DONE,
        REPORT
    } state_e;

    localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);
    localparam logic [7:0] ASSERT_N = 8'(ASSERT_TIMEOUT);

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d, cnt_inc;
    logic [ID_W-1:0] core_job_id_q, core_job_id_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [1:0]      rsp_status_q, rsp_status_d;
    logic            job_ready_q, job_ready_d;
    logic            new_job_q, new_job_d;
    logic            core_start_q, core_start_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d;
`ifdef MINDY_JOB_WATCHDOG_EN
    logic [31:0]     wd_q, wd_d, wd_inc;
`endif

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
`ifdef MINDY_JOB_WATCHDOG_EN
    assign wd_inc  = (wd_q == 32'hFFFF_FFFF) ? wd_q : wd_q + 32'd1;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        core_job_id_d = core_job_id_q;
        rsp_id_d      = rsp_id_q;
        rsp_status_d  = rsp_status_q;
`ifdef MINDY_JOB_WATCHDOG_EN
        wd_d          = wd_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (job_valid && job_ready_q) begin
                    core_job_id_d = job_id;
                    state_d       = PULSE;
                end
            end
            PULSE: begin
                cnt_d   = 8'd0;
                state_d = WAIT_ASSERT;
            end
            WAIT_ASSERT: begin
                if (!core_resetn) begin
                    state_d = WAIT_RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == ASSERT_N) begin
                        state_d      = REPORT;
                        rsp_id_d     = core_job_id_q;
                        rsp_status_d = 2'b10;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (core_resetn) begin
                    cnt_d   = 8'd0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // A drop restarts the whole settle interval from release.
                if (!core_resetn) begin
                    state_d = WAIT_RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == SETTLE_N) begin
                        state_d = START;
                    end
                end
            end
            START: begin
`ifdef MINDY_JOB_WATCHDOG_EN
                wd_d    = 32'd0;
`endif
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
`ifdef MINDY_JOB_WATCHDOG_EN
                wd_d = wd_inc;
`endif
                if (core_done) begin
                    state_d      = REPORT;
                    rsp_id_d     = core_job_id_q;
                    rsp_status_d = {1'b0, core_error};
                end else if (!core_resetn) begin
                    state_d      = REPORT;
                    rsp_id_d     = core_job_id_q;
                    rsp_status_d = 2'b01;
                end
`ifdef MINDY_JOB_WATCHDOG_EN
                else if (watchdog_limit != 32'd0 && wd_inc == watchdog_limit) begin
                    state_d      = REPORT;
                    rsp_id_d     = core_job_id_q;
                    rsp_status_d = 2'b11;
                end
`endif
            end
            REPORT: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        job_ready_d  = (state_d == IDLE);
        new_job_d    = (state_d == PULSE);
        core_start_d = (state_d == START);
        rsp_valid_d  = (state_d == REPORT);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            core_job_id_q <= '0;
            rsp_id_q      <= '0;
            rsp_status_q  <= 2'b00;
            job_ready_q   <= 1'b1;
            new_job_q     <= 1'b0;
            core_start_q  <= 1'b0;
            rsp_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
`ifdef MINDY_JOB_WATCHDOG_EN
            wd_q          <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            core_job_id_q <= core_job_id_d;
            rsp_id_q      <= rsp_id_d;
            rsp_status_q  <= rsp_status_d;
            job_ready_q   <= job_ready_d;
            new_job_q     <= new_job_d;
            core_start_q  <= core_start_d;
            rsp_valid_q   <= rsp_valid_d;
            busy_q        <= busy_d;
`ifdef MINDY_JOB_WATCHDOG_EN
            wd_q          <= wd_d;
`endif
        end
    end

    assign job_ready   = job_ready_q;
    assign new_job     = new_job_q;
    assign core_start  = core_start_q;
    assign core_job_id = core_job_id_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_status  = rsp_status_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mindy_job_launcher.sv
// Scoreboard bench for mindy_job_launcher: random job scenarios drive a core/reset
// model, expected responses queue up and a monitor pops them on each handshake.
module tb_mindy_job_launcher;

    localparam int ID_W   = 8;
    localparam int SETTLE = 4;
    localparam int ATO    = 8;

    localparam int K_OK     = 0;
    localparam int K_TMO    = 1;
    localparam int K_EXTRST = 2;
    localparam int K_RST    = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            job_valid;
    logic            job_ready;
    logic [ID_W-1:0] job_id;
    logic            new_job;
    logic            core_resetn;
    logic            core_start;
    logic [ID_W-1:0] core_job_id;
    logic            core_done;
    logic            core_error;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [1:0]      rsp_status;
    logic            busy;
`ifdef MINDY_JOB_WATCHDOG_EN
    logic [31:0]     watchdog_limit;
`endif

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      st;
    } rsp_t;

    rsp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   hold_low    = 0;
    int   nj_cnt      = 0;
    int   cs_cnt      = 0;

    mindy_job_launcher #(
        .ID_W(ID_W),
        .SETTLE_CYCLES(SETTLE),
        .ASSERT_TIMEOUT(ATO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_id(job_id),
        .new_job(new_job),
        .core_resetn(core_resetn),
        .core_start(core_start),
        .core_job_id(core_job_id),
        .core_done(core_done),
        .core_error(core_error),
`ifdef MINDY_JOB_WATCHDOG_EN
        .watchdog_limit(watchdog_limit),
`endif
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_status(rsp_status),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (new_job === 1'b1) nj_cnt++;
        if (core_start === 1'b1) cs_cnt++;
    end

    // Monitor: drives rsp_ready, checks hold-stability and pops the scoreboard.
    initial begin
        bit   pv;
        bit   pr;
        rsp_t pl;
        rsp_t e;
        pv = 0;
        pr = 0;
        pl = '0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (pv && !pr) begin
                check_eq("rsp_hold_valid", rsp_valid, 1);
                check_eq("rsp_hold_id", rsp_id, pl.id);
                check_eq("rsp_hold_status", rsp_status, pl.st);
            end
            if (pv && pr) check_eq("job_ready_after_rsp", job_ready, 1);
            if (rsp_valid === 1'b1) begin
                check_eq("job_ready_in_report", job_ready, 0);
                check_eq("busy_in_report", busy, 1);
                if (hold_low > 0) begin
                    rsp_ready = 1'b0;
                    hold_low--;
                end else begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                if (rsp_ready) begin
                    check_eq("rsp_pending", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("rsp_id", rsp_id, e.id);
                        check_eq("rsp_status", rsp_status, e.st);
                    end
                end
                pv = 1;
                pr = rsp_ready;
                pl.id = rsp_id;
                pl.st = rsp_status;
            end else begin
                rsp_ready = 1'($urandom);
                pv = 0;
                pr = 0;
            end
        end
    end

    task automatic accept(input logic [ID_W-1:0] id);
        int t;
        t = 0;
        @(negedge clk);
        while (job_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_eq("job_ready_wait", job_ready, 1);
        job_valid = 1'b1;
        job_id    = id;
        @(negedge clk);
        job_valid = 1'b0;
        job_id    = ID_W'($urandom);
        check_eq("new_job_lat", new_job, 1);
        check_eq("core_job_id", core_job_id, id);
        check_eq("busy_after_accept", busy, 1);
        check_eq("job_ready_busy", job_ready, 0);
    endtask

    // Entered at the negedge where core_resetn was just raised.
    task automatic settle_start(input int glitch_at);
        int  g;
        bit  restarted;
        g = glitch_at;
        forever begin
            restarted = 0;
            for (int i = 1; i <= SETTLE + 1 && !restarted; i++) begin
                @(negedge clk);
                if (i == g) begin
                    check_eq("start_before_glitch", core_start, 0);
                    core_resetn = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    core_resetn = 1'b1;
                    g = 0;
                    restarted = 1;
                end else begin
                    check_eq($sformatf("core_start_c%0d", i), core_start,
                             32'(i == SETTLE + 1));
                end
            end
            if (!restarted) break;
        end
    endtask

    function automatic logic [1:0] ref_status(input int kind, input int k,
                                              input bit err);
        if (kind == K_TMO || k > ATO) return 2'b10;
        if (kind == K_EXTRST) return 2'b01;
        return {1'b0, err};
    endfunction

    task automatic reset_path(input int k, input int low_len, input int g);
        repeat (k) @(negedge clk);
        core_resetn = 1'b0;
        for (int i = 0; i < low_len; i++) begin
            @(negedge clk);
            core_done  = ($urandom_range(0, 3) == 0);
            core_error = 1'($urandom);
        end
        @(negedge clk);
        core_done   = 1'b0;
        core_resetn = 1'b1;
        settle_start(g);
    endtask

    task automatic run_job(input int kind, input logic [ID_W-1:0] id, input int k,
                           input int low_len, input int g, input int dly,
                           input bit err, input int hold);
        int   nj0;
        int   cs0;
        int   t;
        rsp_t r;
        nj0 = nj_cnt;
        cs0 = cs_cnt;
        accept(id);
        r.id = id;
        r.st = ref_status(kind, k, err);
        if (kind == K_TMO) begin
            exp_q.push_back(r);
            for (int i = 1; i <= ATO + 1; i++) begin
                @(negedge clk);
                check_eq($sformatf("tmo_valid_c%0d", i), rsp_valid, 32'(i == ATO + 1));
            end
        end else begin
            reset_path(k, low_len, g);
            if (kind == K_RST) begin
                repeat (dly) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check_eq("rst_rsp_valid", rsp_valid, 0);
                check_eq("rst_job_ready", job_ready, 1);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_core_job_id", core_job_id, 0);
                check_eq("rst_rsp_status", rsp_status, 0);
                repeat (2) @(negedge clk);
                core_done  = 1'b1;
                core_error = 1'($urandom);
                @(negedge clk);
                core_done = 1'b0;
                repeat (3) @(negedge clk);
                check_eq("no_rsp_after_reset", rsp_valid, 0);
            end else begin
                exp_q.push_back(r);
                hold_low = hold;
                repeat (dly) @(negedge clk);
                if (kind == K_EXTRST) core_resetn = 1'b0;
                else begin
                    core_done  = 1'b1;
                    core_error = err;
                end
                @(negedge clk);
                core_done   = 1'b0;
                core_error  = 1'($urandom);
                core_resetn = 1'b1;
                check_eq("done_rsp_lat", rsp_valid, 1);
            end
        end
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_eq("rsp_drain", exp_q.size(), 0);
        check_eq("new_job_count", nj_cnt - nj0, 1);
        check_eq("core_start_count", cs_cnt - cs0, (kind == K_TMO) ? 0 : 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        job_valid   = 1'b0;
        job_id      = '0;
        core_resetn = 1'b1;
        core_done   = 1'b0;
        core_error  = 1'b0;
`ifdef MINDY_JOB_WATCHDOG_EN
        watchdog_limit = 32'd0;
`endif
        repeat (3) @(negedge clk);
        check_eq("reset_job_ready", job_ready, 1);
        check_eq("reset_new_job", new_job, 0);
        check_eq("reset_core_start", core_start, 0);
        check_eq("reset_rsp_valid", rsp_valid, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_core_job_id", core_job_id, 0);
        check_eq("reset_rsp_id", rsp_id, 0);
        check_eq("reset_rsp_status", rsp_status, 0);
        reset = 1'b0;

        run_job(K_OK,     8'h5A, 1,   19, 0, 10, 0, 0);
        run_job(K_TMO,    8'hC3, 0,    0, 0,  0, 0, 0);
        run_job(K_OK,     8'h11, 2,    5, 2,  7, 0, 0);
        run_job(K_OK,     8'h22, 3,    4, 0, 10, 1, 6);
        run_job(K_RST,    8'h33, 1,    3, 0,  5, 0, 0);
        run_job(K_EXTRST, 8'h44, 2,    2, 0,  6, 0, 0);
        run_job(K_OK,     8'h55, ATO,  1, SETTLE, 1, 1, 0);
        run_job(K_OK,     8'h66, 1,    0, 0, 300, 0, 2);

`ifdef MINDY_JOB_WATCHDOG_EN
        begin
            rsp_t r;
            watchdog_limit = 32'd100;
            accept(8'h77);
            reset_path(1, 2, 0);
            r.id = 8'h77;
            r.st = 2'b11;
            exp_q.push_back(r);
            for (int i = 1; i <= 101; i++) begin
                @(negedge clk);
                if (i >= 99) check_eq($sformatf("wd_valid_c%0d", i), rsp_valid, 32'(i == 101));
            end
            repeat (20) @(negedge clk);
            check_eq("wd_drain", exp_q.size(), 0);
            watchdog_limit = 32'd0;
            accept(8'h78);
            reset_path(1, 2, 0);
            repeat (1000) @(negedge clk);
            check_eq("wd_disabled", rsp_valid, 0);
            r.id = 8'h78;
            r.st = 2'b00;
            exp_q.push_back(r);
            core_done = 1'b1;
            core_error = 1'b0;
            @(negedge clk);
            core_done = 1'b0;
            repeat (20) @(negedge clk);
            check_eq("wd_off_drain", exp_q.size(), 0);
        end
`endif

        for (int n = 0; n < 40; n++) begin
            int kind;
            int sel;
            sel = $urandom_range(0, 9);
            kind = (sel < 5) ? K_OK : (sel < 7) ? K_TMO : (sel < 9) ? K_EXTRST : K_RST;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                core_done = 1'($urandom);
            end
            core_done = 1'b0;
            run_job(kind, ID_W'($urandom), $urandom_range(1, ATO),
                    $urandom_range(0, 6), $urandom_range(0, SETTLE),
                    $urandom_range(1, 20), 1'($urandom), $urandom_range(0, 6));
        end

        repeat (5) @(negedge clk);
        check_eq("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
